// File: rtl/trace_arb_pkg.sv
// trace_arb_pkg: shared state encoding, register offsets and sizing helpers for the trace arbiter
package trace_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int CNT_WIDTH = 32;
  localparam int NUM_SRC_DEFAULT = 4;
  localparam int GRANT_IDX_WIDTH = $clog2(NUM_SRC_DEFAULT);
  localparam int REG_ENABLE = 'h10;
  localparam int REG_STATUS = 'h14;
  localparam int REG_CLEAR = 'h18;
  localparam int REG_CNT_BASE = 'h20;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular first-one finder starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  // Scan from farthest to nearest so the closest request at or after ptr wins.
  always_comb begin
    found = |req;
    idx = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter: round-robin packet arbiter feeding one trace writer, with drain of disabled sources and ctrl-bus counters
module trace_stream_arbiter
  import trace_arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_ADDR_WIDTH = 16,
  parameter int MAX_GRANT = 16,
  parameter int REGADDR_ENABLE = REG_ENABLE,
  parameter int REGADDR_STATUS = REG_STATUS,
  parameter int REGADDR_CLEAR = REG_CLEAR,
  parameter int REGADDR_CNT_BASE = REG_CNT_BASE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ctrl_wen,
  input  logic [CTRL_ADDR_WIDTH-1:0]      ctrl_waddr,
  input  logic [31:0]                     ctrl_wdata,
  input  logic                            ctrl_ren,
  input  logic [CTRL_ADDR_WIDTH-1:0]      ctrl_raddr,
  output logic [31:0]                     ctrl_rdata,
  input  logic [NUM_SRC-1:0]              s_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic [NUM_SRC-1:0]              s_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  input  logic                            o_ready
);
  localparam int GW = idx_width(NUM_SRC);
  localparam int BW = idx_width(MAX_GRANT);
  localparam logic [GW-1:0] LAST_SRC = GW'(NUM_SRC - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_GRANT - 1);
  state_t state, state_d;
  logic [GW-1:0] grant, grant_d, rr_ptr, rr_ptr_d, pick_idx;
  logic [BW-1:0] beat_cnt, beat_cnt_d;
  logic [NUM_SRC-1:0] enable, owned, acc_inc, drop_inc;
  logic [CNT_WIDTH-1:0] acc_cnt [NUM_SRC];
  logic [CNT_WIDTH-1:0] drop_cnt [NUM_SRC];
  logic pick_found, beat, release_g, clear, en_wr;
  logic [31:0] rdata_d;
  logic unused;
  assign unused = ^ctrl_wdata;
  assign clear = ctrl_wen && ctrl_waddr == CTRL_ADDR_WIDTH'(REGADDR_CLEAR);
  assign en_wr = ctrl_wen && ctrl_waddr == CTRL_ADDR_WIDTH'(REGADDR_ENABLE);
  assign owned = state == GRANT ? NUM_SRC'(1) << grant : '0;
  rr_pick #(.N(NUM_SRC), .W(GW)) u_pick (
    .req   (s_valid & enable),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );
  // The granted source passes straight through; disabled non-granted sources are drained.
  always_comb begin
    o_valid = state == GRANT && s_valid[grant];
    o_data = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    beat = o_valid && o_ready;
    release_g = beat && (s_last[grant] || beat_cnt == LAST_BEAT);
    for (int i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = owned[i] ? o_ready : !enable[i];
      acc_inc[i] = owned[i] && beat;
      drop_inc[i] = !owned[i] && !enable[i] && s_valid[i];
    end
    state_d = state;
    grant_d = grant;
    rr_ptr_d = rr_ptr;
    beat_cnt_d = beat_cnt;
    if (state == IDLE && pick_found) begin
      state_d = GRANT;
      grant_d = pick_idx;
      beat_cnt_d = '0;
    end else if (state == GRANT && beat) begin
      beat_cnt_d = beat_cnt + 1'b1;
      if (release_g) begin
        state_d = IDLE;
        rr_ptr_d = grant == LAST_SRC ? '0 : grant + 1'b1;
      end
    end
  end
  always_comb begin
    rdata_d = '0;
    if (ctrl_raddr == CTRL_ADDR_WIDTH'(REGADDR_ENABLE)) rdata_d[NUM_SRC-1:0] = enable;
    if (ctrl_raddr == CTRL_ADDR_WIDTH'(REGADDR_STATUS)) begin
      rdata_d[0] = state == GRANT;
      rdata_d[8 +: GW] = grant;
      rdata_d[16 +: GW] = rr_ptr;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ctrl_raddr == CTRL_ADDR_WIDTH'(REGADDR_CNT_BASE + 8 * i)) rdata_d = acc_cnt[i];
      if (ctrl_raddr == CTRL_ADDR_WIDTH'(REGADDR_CNT_BASE + 8 * i + 4)) rdata_d = drop_cnt[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      enable <= '1;
      ctrl_rdata <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      rr_ptr <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
      if (en_wr) enable <= ctrl_wdata[NUM_SRC-1:0];
      if (ctrl_ren) ctrl_rdata <= rdata_d;
    end
  end
  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst || clear) begin
        acc_cnt[i] <= '0;
        drop_cnt[i] <= '0;
      end else begin
        if (acc_inc[i]) acc_cnt[i] <= acc_cnt[i] + 1'b1;
        if (drop_inc[i]) drop_cnt[i] <= drop_cnt[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb_trace_stream_arbiter: directed and randomized checks of the arbiter against a packet-level reference model
module tb_trace_stream_arbiter;
  localparam int N = 4;
  localparam int DW = 64;
  localparam int MG = 16;
  logic clk = 0;
  logic rst = 1;
  logic ctrl_wen = 0;
  logic [15:0] ctrl_waddr = 0;
  logic [31:0] ctrl_wdata = 0;
  logic ctrl_ren = 0;
  logic [15:0] ctrl_raddr = 0;
  logic [31:0] ctrl_rdata;
  logic [N-1:0] s_valid = 0;
  logic [N-1:0] s_last = 0;
  logic [N-1:0] s_ready;
  logic [N*DW-1:0] s_data = 0;
  logic o_valid;
  logic [DW-1:0] o_data;
  logic o_ready = 1;

  always #5 clk = ~clk;

  trace_stream_arbiter dut (
    .clk(clk), .rst(rst),
    .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [64:0] q [N][$];
  int sseq [N];
  logic [N-1:0] gate = '1;
  logic [DW-1:0] fwd [$];
  int fwd_cyc [$];
  bit m_busy;
  int m_g, m_ptr, m_n;
  logic [N-1:0] m_en;
  logic [31:0] m_acc [N];
  logic [31:0] m_drop [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_n = 0; m_en = '1;
    for (int i = 0; i < N; i++) begin m_acc[i] = 0; m_drop[i] = 0; end
  endtask

  task automatic push(input int s, input int n);
    for (int b = 0; b < n; b++) begin
      q[s].push_back({b == n - 1, 8'(s), 24'(sseq[s]), 32'($urandom)});
      sseq[s]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 0; s_last[i] = 0; s_data[i*DW +: DW] = '0;
      if (q[i].size() > 0) begin
        s_valid[i] = gate[i];
        s_last[i] = q[i][0][64];
        s_data[i*DW +: DW] = q[i][0][DW-1:0];
      end
    end
  endtask

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < N; i++) t += q[i].size();
    return t;
  endfunction

  // One clock: drive, check outputs mid-cycle, advance the reference model across the edge.
  task automatic cycle();
    logic [N-1:0] rdy, hs;
    bit beat;
    drive();
    @(negedge clk);
    for (int i = 0; i < N; i++) rdy[i] = (m_busy && m_g == i) ? o_ready : !m_en[i];
    chk("o_valid", o_valid, m_busy && s_valid[m_g]);
    chk("s_ready", s_ready, rdy);
    if (m_busy && s_valid[m_g]) chk("o_data", o_data, q[m_g][0][DW-1:0]);
    if (o_valid === 1'b1 && o_ready) begin fwd.push_back(o_data); fwd_cyc.push_back(cyc); end
    hs = s_valid & rdy;
    beat = m_busy && s_valid[m_g] && o_ready;
    for (int i = 0; i < N; i++) if (hs[i] && !(m_busy && m_g == i)) m_drop[i]++;
    if (m_busy) begin
      if (beat) begin
        m_acc[m_g]++; m_n++;
        if (s_last[m_g] || m_n == MG) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (!m_busy && s_valid[j] && m_en[j]) begin m_busy = 1; m_g = j; m_n = 0; end
      end
    end
    if (ctrl_wen && ctrl_waddr == 16'h18)
      for (int i = 0; i < N; i++) begin m_acc[i] = 0; m_drop[i] = 0; end
    if (ctrl_wen && ctrl_waddr == 16'h10) m_en = ctrl_wdata[N-1:0];
    if (rst) model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(q[i].pop_front());
    ctrl_wen = 0; ctrl_ren = 0; cyc++;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    ctrl_ren = 1; ctrl_raddr = a; cycle();
    chk(tag, ctrl_rdata, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    ctrl_wen = 1; ctrl_waddr = a; ctrl_wdata = d; cycle();
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic fwd_clear();
    fwd.delete(); fwd_cyc.delete();
  endtask

  initial begin
    int c, b1, op, si;
    bit d;
    logic [31:0] ex;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rd("rst_enable", 16'h10, 32'hF);
    rd("rst_status", 16'h14, 32'h0);
    rd("rst_acc0", 16'h20, 32'h0);

    fwd_clear(); push(0, 3); c = cyc;
    repeat (6) cycle();
    chk("t1_count", fwd.size(), 3);
    chk("t1_latency", fwd_cyc[0], c + 1);
    for (int k = 0; k < 3; k++) chk("t1_beat", fwd[k][63:32], {8'd0, 24'(k)});
    rd("t1_status", 16'h14, 32'h0001_0000);
    rd("t1_acc0", 16'h20, 32'd3);

    do_reset(); fwd_clear(); push(0, 2); push(2, 2); c = cyc;
    repeat (8) cycle();
    chk("t2_count", fwd.size(), 4);
    chk("t2_src0", fwd[1][63:56], 8'd0);
    chk("t2_src2", fwd[2][63:56], 8'd2);
    chk("t2_first", fwd_cyc[0], c + 1);
    chk("t2_bubble", fwd_cyc[2] - fwd_cyc[1], 2);
    rd("t2_status", 16'h14, 32'h0003_0200);

    fwd_clear(); b1 = sseq[1]; push(1, 40); cycle(); push(3, 3);
    repeat (50) cycle();
    chk("t3_count", fwd.size(), 43);
    chk("t3_beat16", fwd[15][63:32], {8'd1, 24'(b1 + 15)});
    chk("t3_rot3", fwd[16][63:56], 8'd3);
    chk("t3_end3", fwd[18][63:56], 8'd3);
    chk("t3_beat17", fwd[19][63:32], {8'd1, 24'(b1 + 16)});
    chk("t3_beat40", fwd[42][63:32], {8'd1, 24'(b1 + 39)});

    wr(16'h10, 32'hD); fwd_clear(); push(1, 5);
    repeat (7) cycle();
    chk("t4_no_fwd", fwd.size(), 0);
    rd("t4_drop1", 16'h2C, 32'd5);
    rd("t4_acc1", 16'h28, 32'd40);
    rd("t4_enable", 16'h10, 32'hD);
    wr(16'h10, 32'hF);

    fwd_clear(); push(2, 2); b1 = sseq[2];
    o_ready = 1; cycle(); cycle();
    o_ready = 0; rd("t5_busy", 16'h14, 32'h0002_0201);
    cycle();
    o_ready = 1; cycle(); cycle();
    chk("t5_count", fwd.size(), 2);
    chk("t5_gap", fwd_cyc[1] - fwd_cyc[0], 3);
    chk("t5_beat1", fwd[0][63:32], {8'd2, 24'(b1 - 2)});
    chk("t5_beat2", fwd[1][63:32], {8'd2, 24'(b1 - 1)});

    fwd_clear(); push(0, 1); cycle();
    wr(16'h18, 32'h1);
    chk("t6_fwd", fwd.size(), 1);
    rd("t6_acc0", 16'h20, 32'h0);
    rd("t6_drop1", 16'h2C, 32'h0);
    rd("t6_enable", 16'h10, 32'hF);
    cycle();
    chk("t6_hold", ctrl_rdata, 32'hF);
    rd("t6_unmapped", 16'h7C, 32'h0);

    fwd_clear(); push(0, 6);
    repeat (3) cycle();
    rst = 1; cycle(); rst = 0;
    chk("t7_ovalid", o_valid, 1'b0);
    repeat (8) cycle();
    chk("t7_count", fwd.size(), 6);
    rd("t7_acc0", 16'h20, 32'd3);
    rd("t7_status", 16'h14, 32'h0001_0000);

    for (int t = 0; t < 3000; t++) begin
      gate = N'($urandom);
      o_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) begin
        si = $urandom_range(0, N - 1);
        if (q[si].size() < 30) push(si, $urandom_range(1, 20));
      end
      op = $urandom_range(0, 199);
      if (op < 2) begin ctrl_wen = 1; ctrl_waddr = 16'h10; ctrl_wdata = $urandom; end
      else if (op == 2) begin ctrl_wen = 1; ctrl_waddr = 16'h18; ctrl_wdata = $urandom; end
      if (op >= 3 && op < 10) begin
        si = $urandom_range(0, N - 1); d = 1'($urandom);
        ex = d ? m_drop[si] : m_acc[si];
        ctrl_ren = 1; ctrl_raddr = 16'(32'h20 + 8 * si + (d ? 4 : 0));
        cycle();
        chk("rnd_cnt", ctrl_rdata, ex);
      end else cycle();
    end
    gate = '1; o_ready = 1;
    wr(16'h10, 32'hF);
    for (int t = 0; t < 3000 && pending() > 0; t++) cycle();
    chk("drain_empty", pending(), 0);
    repeat (3) cycle();
    for (int i = 0; i < N; i++) begin
      rd("fin_acc", 16'(32'h20 + 8 * i), m_acc[i]);
      rd("fin_drop", 16'(32'h24 + 8 * i), m_drop[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
